l1i_cache_nway: RTL and testbench

//  Parametrised N-way set-associative L1 instruction cache with its own control FSM.

---
 rtl/l1i_pkg.sv | 33 +++
 rtl/l1i_way_array.sv | 29 ++
 rtl/l1i_cache_nway.sv | 170 +++++++++++++++++
 tb/tb_l1i_cache_nway.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l1i_pkg.sv
// Shared types and geometry helpers for the N-way L1 instruction cache.
// Lines up to 1024 bits (128 bytes) are supported by the word selector.
package l1i_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_AR,
    S_REFILL_R,
    S_RESP,
    S_FLUSH
  } state_t;

  localparam int MAX_LINE_W = 1024;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
    return addr_w - idx_w(sets) - off_w(line_bytes);
  endfunction

  function automatic logic [31:0] word_sel(input logic [MAX_LINE_W-1:0] line,
                                           input logic [4:0] word);
    return line[{word, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/l1i_way_array.sv
// One way of the instruction cache: SETS entries of {tag, line}, 1-cycle synchronous
// read and write. Valid bits live in the top level so flush can clear them at once.
module l1i_way_array
  import l1i_pkg::*;
#(
  parameter int SETS   = 32,
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_line
);

  logic [TAG_W+LINE_W-1:0] r_mem [SETS];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= {i_wr_tag, i_wr_line};
    if (i_rd_en) {o_rd_tag, o_rd_line} <= r_mem[i_rd_idx];
  end

endmodule

// File: rtl/l1i_cache_nway.sv
// N-way set-associative L1 instruction cache with refill FSM, invalid-first plus
// per-set round-robin replacement, single-cycle flush and hit/miss counters.
module l1i_cache_nway
  import l1i_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 16,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDR_W-1:0]       cpu_req_addr,
  output logic                    cpu_rsp_valid,
  output logic [31:0]             cpu_rsp_data,
  input  logic                    flush,
  output logic                    mem_ar_valid,
  input  logic                    mem_ar_ready,
  output logic [ADDR_W-1:0]       mem_ar_addr,
  input  logic                    mem_r_valid,
  output logic                    mem_r_ready,
  input  logic [8*LINE_BYTES-1:0] mem_r_data,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic [WAYS-1:0][SETS-1:0] r_valid;
  logic [RR_W-1:0]         r_rr [SETS];
  logic [RR_W-1:0]         r_victim;
  logic                    r_all_valid;
  logic                    r_flush_pend;
  logic [31:0]             r_rsp_word;
  logic [CNT_W-1:0]        r_hit_cnt;
  logic [CNT_W-1:0]        r_miss_cnt;

  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [4:0]              w_word;
  logic                    w_accept;
  logic                    w_fill;
  logic                    w_lookup_hit;
  logic [WAYS-1:0]         w_hit;
  logic [WAYS-1:0]         w_set_valid;
  logic [LINE_W-1:0]       w_hit_line;
  logic [31:0]             w_hit_word;
  logic [RR_W-1:0]         w_victim;
  logic [TAG_W-1:0]        w_rd_tag  [WAYS];
  logic [LINE_W-1:0]       w_rd_line [WAYS];

  assign w_idx    = r_addr[OFF_W +: IDX_W];
  assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
  assign w_word   = 5'(r_addr[OFF_W-1:0] >> 2);
  assign w_accept = cpu_req_valid && cpu_req_ready;
  assign w_fill   = (r_state == S_REFILL_R) && mem_r_valid;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    l1i_way_array #(
      .SETS   (SETS),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W)
    ) u_way (
      .clk       (clk),
      .i_rd_en   (w_accept),
      .i_rd_idx  (cpu_req_addr[OFF_W +: IDX_W]),
      .o_rd_tag  (w_rd_tag[g]),
      .o_rd_line (w_rd_line[g]),
      .i_wr_en   (w_fill && (r_victim == RR_W'(g))),
      .i_wr_idx  (w_idx),
      .i_wr_tag  (w_tag),
      .i_wr_line (mem_r_data)
    );
  end

  always_comb begin
    w_hit       = '0;
    w_set_valid = '0;
    w_hit_line  = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_set_valid[w] = r_valid[w][w_idx];
      w_hit[w]       = r_valid[w][w_idx] && (w_rd_tag[w] == w_tag);
      if (w_hit[w]) w_hit_line = w_hit_line | w_rd_line[w];
    end
  end

  // Lowest-index invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    w_victim = r_rr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_set_valid[w]) w_victim = RR_W'(w);
    end
  end

  assign w_lookup_hit = (r_state == S_LOOKUP) && (|w_hit);
  assign w_hit_word   = word_sel(MAX_LINE_W'(w_hit_line), w_word);

  assign cpu_req_ready = (r_state == S_IDLE) && !flush && !r_flush_pend;
  assign cpu_rsp_valid = w_lookup_hit || (r_state == S_RESP);
  assign cpu_rsp_data  = (r_state == S_RESP) ? r_rsp_word :
                         (w_lookup_hit ? w_hit_word : 32'h0);
  assign mem_ar_valid  = (r_state == S_REFILL_AR);
  assign mem_ar_addr   = mem_ar_valid ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_r_ready   = (r_state == S_REFILL_R);
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_rr         <= '{default: '0};
      r_flush_pend <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (r_state != S_IDLE && flush) r_flush_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (flush || r_flush_pend) r_state <= S_FLUSH;
          else if (cpu_req_valid)    r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (|w_hit) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            r_state   <= S_IDLE;
          end else begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            r_state    <= S_REFILL_AR;
          end
        end
        S_REFILL_AR: if (mem_ar_ready) r_state <= S_REFILL_R;
        S_REFILL_R: begin
          if (mem_r_valid) begin
            r_valid[r_victim][w_idx] <= 1'b1;
            if (r_all_valid && WAYS > 1) r_rr[w_idx] <= r_rr[w_idx] + RR_W'(1);
            r_state <= S_RESP;
          end
        end
        S_RESP: r_state <= S_IDLE;
        S_FLUSH: begin
          r_valid      <= '0;
          r_flush_pend <= flush;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_addr <= cpu_req_addr;
    if (r_state == S_LOOKUP) begin
      r_victim    <= w_victim;
      r_all_valid <= &w_set_valid;
    end
    if (w_fill) r_rsp_word <= word_sel(MAX_LINE_W'(mem_r_data), w_word);
  end

endmodule

// File: tb/tb_l1i_cache_nway.sv
// Randomised self-checking bench for l1i_cache_nway against a set/way reference model.
module tb_l1i_cache_nway;

  localparam int ADDR_W = 32, SETS = 32, WAYS = 2, LINE_BYTES = 16, CNT_W = 32;
  localparam int LINE_W = 8 * LINE_BYTES;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_valid, cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_rsp_valid;
  logic [31:0]       cpu_rsp_data;
  logic              flush;
  logic              mem_ar_valid, mem_ar_ready;
  logic [ADDR_W-1:0] mem_ar_addr;
  logic              mem_r_valid, mem_r_ready;
  logic [LINE_W-1:0] mem_r_data;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  l1i_cache_nway #(
    .ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data), .flush(flush),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
    .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: which tag each way holds per set, plus replacement pointers.
  bit          m_valid [WAYS][SETS];
  int unsigned m_tag   [WAYS][SETS];
  int          m_rr    [SETS];
  int          m_hits, m_misses;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (la == 32'h0000_1000) return 128'h44444444_33333333_22222222_11111111;
    for (int i = 0; i < LINE_BYTES / 4; i++)
      l[i*32 +: 32] = la ^ (32'h0101_0101 * i) ^ 32'hC0DE_0000;
    return l;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_flush();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input int ar_wait, input int r_wait, input bit fl);
    int          idx, word, hitway, victim, cyc;
    int unsigned tag;
    bit          allv;
    logic [31:0] la, exp_word;
    logic [LINE_W-1:0] line;
    idx  = int'((a / LINE_BYTES) % SETS);
    tag  = a / (LINE_BYTES * SETS);
    word = int'((a % LINE_BYTES) / 4);
    la   = a - (a % LINE_BYTES);
    line = mem_line(la);
    exp_word = line[word*32 +: 32];
    hitway = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tag) hitway = w;

    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    #1;
    cyc = 0;
    while (!cpu_req_ready && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    check_eq("req_ready", cpu_req_ready, 1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    #1;
    if (hitway >= 0) begin
      m_hits++;
      check_eq("hit_rsp_valid", cpu_rsp_valid, 1);
      check_eq("hit_rsp_data", cpu_rsp_data, exp_word);
      check_eq("hit_no_ar", mem_ar_valid, 0);
    end else begin
      m_misses++;
      victim = -1;
      allv = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[w][idx]) begin victim = w; allv = 1'b0; end
      if (allv) begin
        victim = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % WAYS;
      end
      check_eq("miss_no_early_rsp", cpu_rsp_valid, 0);
      @(negedge clk); #1;
      for (int i = 0; i <= ar_wait; i++) begin
        check_eq("ar_valid", mem_ar_valid, 1);
        check_eq("ar_addr", mem_ar_addr, la);
        check_eq("busy_req_ready", cpu_req_ready, 0);
        if (i == ar_wait) mem_ar_ready = 1'b1;
        @(negedge clk);
      end
      mem_ar_ready = 1'b0;
      #1;
      check_eq("r_ready", mem_r_ready, 1);
      check_eq("ar_dropped", mem_ar_valid, 0);
      for (int i = 0; i < r_wait; i++) begin
        if (fl && i == 0) flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("r_ready_hold", mem_r_ready, 1);
      end
      mem_r_valid = 1'b1;
      mem_r_data  = line;
      @(negedge clk);
      mem_r_valid = 1'b0;
      mem_r_data  = '0;
      #1;
      check_eq("miss_rsp_valid", cpu_rsp_valid, 1);
      check_eq("miss_rsp_data", cpu_rsp_data, exp_word);
      m_valid[victim][idx] = 1'b1;
      m_tag[victim][idx]   = tag;
    end
    @(negedge clk); #1;
    check_eq("rsp_one_cycle", cpu_rsp_valid, 0);
    check_eq("hit_cnt", hit_cnt, m_hits);
    check_eq("miss_cnt", miss_cnt, m_misses);
    if (fl && hitway < 0 && r_wait > 0) begin
      check_eq("pend_blocks_req", cpu_req_ready, 0);
      @(negedge clk); #1;
      check_eq("flush_state_blocks", cpu_req_ready, 0);
      @(negedge clk); #1;
      check_eq("ready_after_flush", cpu_req_ready, 1);
      model_flush();
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_addr = '0;
    flush = 1'b0;
    mem_ar_ready = 1'b0;
    mem_r_valid = 1'b0;
    mem_r_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_req_ready", cpu_req_ready, 1);
    check_eq("rst_rsp_valid", cpu_rsp_valid, 0);
    check_eq("rst_ar_valid", mem_ar_valid, 0);
    check_eq("rst_r_ready", mem_r_ready, 0);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);

    fetch(32'h0000_1004, 0, 0, 1'b0);   // cold miss
    fetch(32'h0000_1008, 0, 0, 1'b0);   // hit in same line
    fetch(32'h0000_1000, 0, 1, 1'b0);
    fetch(32'h0000_3000, 1, 0, 1'b0);
    fetch(32'h0000_5000, 0, 0, 1'b0);   // evicts way0 through round-robin
    fetch(32'h0000_3000, 0, 0, 1'b0);
    fetch(32'h0000_1000, 0, 0, 1'b0);
    fetch(32'h0000_2000, 5, 0, 1'b0);   // long AR stall
    fetch(32'h0000_7004, 0, 2, 1'b1);   // flush during refill
    fetch(32'h0000_7004, 0, 0, 1'b0);

    // Flush and request in the same idle cycle: flush wins.
    @(negedge clk);
    flush = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr = 32'h0000_7008;
    #1;
    check_eq("flush_vs_req_ready", cpu_req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush_cycle_ready", cpu_req_ready, 0);
    check_eq("flush_cycle_no_rsp", cpu_rsp_valid, 0);
    model_flush();
    @(negedge clk); #1;
    check_eq("post_flush_ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b0;
    fetch(32'h0000_7008, 0, 0, 1'b0);

    // Reset while waiting for the refill line.
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr = 32'h0000_9000;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    mem_ar_ready = 1'b1;
    @(negedge clk);
    mem_ar_ready = 1'b0;
    #1;
    check_eq("pre_rst_r_ready", mem_r_ready, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_r_ready", mem_r_ready, 0);
    check_eq("midrst_ar_valid", mem_ar_valid, 0);
    check_eq("midrst_rsp_valid", cpu_rsp_valid, 0);
    check_eq("midrst_req_ready", cpu_req_ready, 1);
    check_eq("midrst_miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    fetch(32'h0000_9000, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int unsigned tags [4] = '{8, 24, 40, 3};
      logic [31:0] a;
      int rw;
      rw = $urandom_range(0, 3);
      a = (tags[$urandom_range(0, 3)] << 9) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2);
      fetch(a, $urandom_range(0, 3), rw, ($urandom_range(0, 9) == 0) && rw > 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
